// File: rtl/pcie_rq_np_throttle.sv
// Non-posted read throttle between the DMA RQ stream and the PCIe core requester port.
// Optional statistics outputs are enabled by defining PCIE_RQ_NP_STATS_EN.
module pcie_rq_np_throttle #(
    parameter int MAX_OUTSTANDING = 32,
    parameter int CREDIT_HOLDOFF  = 4
) (
    input  logic         user_clk,
    input  logic         reset_n,
    input  logic [255:0] in_rq_tdata,
    input  logic [59:0]  in_rq_tuser,
    input  logic [7:0]   in_rq_tkeep,
    input  logic         in_rq_tlast,
    input  logic         in_rq_tvalid,
    output logic         in_rq_tready,
    output logic [255:0] out_rq_tdata,
    output logic [59:0]  out_rq_tuser,
    output logic [7:0]   out_rq_tkeep,
    output logic         out_rq_tlast,
    output logic         out_rq_tvalid,
    input  logic         out_rq_tready,
    input  logic [1:0]   pcie_tfc_nph_av,
    input  logic [31:0]  rc_tdata_lo,
    input  logic         rc_tlast,
    input  logic         rc_tvalid,
    input  logic         rc_tready,
    output logic [7:0]   np_outstanding,
    output logic         np_stalled
`ifdef PCIE_RQ_NP_STATS_EN
    ,
    output logic [31:0]  stat_np_issued,
    output logic [31:0]  stat_stall_cycles
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_e;

    localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUTSTANDING);
    localparam logic [3:0] HOLDOFF_C = 4'(CREDIT_HOLDOFF);

    state_e     state_q, state_d;
    logic [7:0] np_cnt_q, np_cnt_d;
    logic [3:0] holdoff_q, holdoff_d;
    logic       rc_sop_q, rc_sop_d;
    logic       is_mrd_s, credit_ok_s, mrd_admit_s;
    logic       rc_acc_s, cpl_done_s;
    logic       rc_lo_unused_s;

    assign out_rq_tdata   = in_rq_tdata;
    assign out_rq_tuser   = in_rq_tuser;
    assign out_rq_tkeep   = in_rq_tkeep;
    assign out_rq_tlast   = in_rq_tlast;
    assign np_outstanding = np_cnt_q;
    assign rc_lo_unused_s = ^{rc_tdata_lo[31], rc_tdata_lo[29:0]};

    // Gate FSM: the SOP is held upstream in IDLE and only flows once in PASS
    always_comb begin
        state_d       = state_q;
        out_rq_tvalid = 1'b0;
        in_rq_tready  = 1'b0;
        np_stalled    = 1'b0;
        mrd_admit_s   = 1'b0;
        is_mrd_s      = (in_rq_tdata[78:75] == 4'b0000);
        credit_ok_s   = (pcie_tfc_nph_av >= 2'd2) && (np_cnt_q < MAX_OUT_C) && (holdoff_q == 4'd0);
        case (state_q)
            ST_IDLE: begin
                if (in_rq_tvalid && (!is_mrd_s || credit_ok_s)) begin
                    state_d     = ST_PASS;
                    mrd_admit_s = is_mrd_s;
                end else begin
                    np_stalled  = in_rq_tvalid;
                end
            end
            ST_PASS: begin
                out_rq_tvalid = in_rq_tvalid;
                in_rq_tready  = out_rq_tready;
                if (in_rq_tvalid && out_rq_tready && in_rq_tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PASS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outstanding-read bookkeeping from admits and snooped completions
    always_comb begin
        rc_acc_s   = rc_tvalid && rc_tready;
        cpl_done_s = rc_acc_s && rc_sop_q && rc_tdata_lo[30];
        if (rc_acc_s) begin
            rc_sop_d = rc_tlast;
        end else begin
            rc_sop_d = rc_sop_q;
        end
        if (mrd_admit_s) begin
            holdoff_d = HOLDOFF_C;
        end else if (holdoff_q != 4'd0) begin
            holdoff_d = holdoff_q - 4'd1;
        end else begin
            holdoff_d = holdoff_q;
        end
        case ({mrd_admit_s, cpl_done_s})
            2'b10:   np_cnt_d = np_cnt_q + 8'd1;
            2'b01:   np_cnt_d = (np_cnt_q != 8'd0) ? np_cnt_q - 8'd1 : np_cnt_q;
            default: np_cnt_d = np_cnt_q;
        endcase
    end

    // State and counter registers
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            np_cnt_q  <= 8'd0;
            holdoff_q <= 4'd0;
            rc_sop_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            np_cnt_q  <= np_cnt_d;
            holdoff_q <= holdoff_d;
            rc_sop_q  <= rc_sop_d;
        end
    end

`ifdef PCIE_RQ_NP_STATS_EN
    logic [31:0] stat_np_issued_q, stat_stall_cycles_q;

    assign stat_np_issued    = stat_np_issued_q;
    assign stat_stall_cycles = stat_stall_cycles_q;

    // Saturating statistics counters
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_np_issued_q    <= 32'd0;
            stat_stall_cycles_q <= 32'd0;
        end else begin
            if (mrd_admit_s && (stat_np_issued_q != 32'hFFFF_FFFF)) begin
                stat_np_issued_q <= stat_np_issued_q + 32'd1;
            end else begin
                stat_np_issued_q <= stat_np_issued_q;
            end
            if (np_stalled && (stat_stall_cycles_q != 32'hFFFF_FFFF)) begin
                stat_stall_cycles_q <= stat_stall_cycles_q + 32'd1;
            end else begin
                stat_stall_cycles_q <= stat_stall_cycles_q;
            end
        end
    end
`endif

    pcie_rq_np_throttle_chk u_chk (
        .clk       (user_clk),
        .rst_n     (reset_n),
        .cpl_done  (cpl_done_s),
        .mrd_admit (mrd_admit_s),
        .cnt       (np_cnt_q)
    );

endmodule

// A completion with nothing outstanding means the request/completion accounting is broken.
module pcie_rq_np_throttle_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       cpl_done,
    input logic       mrd_admit,
    input logic [7:0] cnt
);
    underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(cpl_done && !mrd_admit && (cnt == 8'd0)))
        else $error("np_outstanding decrement requested at zero");
endmodule

// File: tb/tb_pcie_rq_np_throttle.sv
// Randomized + directed bench for pcie_rq_np_throttle against a cycle-level behavioural model.
module tb_pcie_rq_np_throttle;
    localparam int MAXO = 2;
    localparam int HOLD = 4;

    logic         user_clk = 1'b0;
    logic         reset_n;
    logic [255:0] in_rq_tdata;
    logic [59:0]  in_rq_tuser;
    logic [7:0]   in_rq_tkeep;
    logic         in_rq_tlast, in_rq_tvalid, in_rq_tready;
    logic [255:0] out_rq_tdata;
    logic [59:0]  out_rq_tuser;
    logic [7:0]   out_rq_tkeep;
    logic         out_rq_tlast, out_rq_tvalid, out_rq_tready;
    logic [1:0]   pcie_tfc_nph_av;
    logic [31:0]  rc_tdata_lo;
    logic         rc_tlast, rc_tvalid, rc_tready;
    logic [7:0]   np_outstanding;
    logic         np_stalled;
`ifdef PCIE_RQ_NP_STATS_EN
    logic [31:0]  stat_np_issued, stat_stall_cycles;
`endif

    always #5 user_clk = ~user_clk;

    pcie_rq_np_throttle #(.MAX_OUTSTANDING(MAXO), .CREDIT_HOLDOFF(HOLD)) dut (
        .user_clk(user_clk), .reset_n(reset_n),
        .in_rq_tdata(in_rq_tdata), .in_rq_tuser(in_rq_tuser), .in_rq_tkeep(in_rq_tkeep),
        .in_rq_tlast(in_rq_tlast), .in_rq_tvalid(in_rq_tvalid), .in_rq_tready(in_rq_tready),
        .out_rq_tdata(out_rq_tdata), .out_rq_tuser(out_rq_tuser), .out_rq_tkeep(out_rq_tkeep),
        .out_rq_tlast(out_rq_tlast), .out_rq_tvalid(out_rq_tvalid), .out_rq_tready(out_rq_tready),
        .pcie_tfc_nph_av(pcie_tfc_nph_av), .rc_tdata_lo(rc_tdata_lo), .rc_tlast(rc_tlast),
        .rc_tvalid(rc_tvalid), .rc_tready(rc_tready),
        .np_outstanding(np_outstanding), .np_stalled(np_stalled)
`ifdef PCIE_RQ_NP_STATS_EN
        , .stat_np_issued(stat_np_issued), .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    typedef struct {
        logic [255:0] d;
        logic [59:0]  u;
        logic [7:0]   k;
        logic         l;
        logic         sop;
        logic         mrd;
    } beat_t;

    typedef struct {
        logic [31:0] w;
        logic        first;
        logic        l;
    } rcb_t;

    beat_t send_q[$];
    beat_t exp_q[$];
    rcb_t  rc_q[$];
    int    mrd_sop_cyc[$];

    int n_cmp = 0;
    int n_err = 0;
    int m_cnt, m_cycle, m_last_admit, m_issued, m_stalls;
    logic m_busy;
    int obs_stall, n_out_beats;
    logic [255:0] saved_d;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, m_cycle);
        end
    endtask

    task automatic push_tlp(input logic mrd, input int nb);
        beat_t b;
        logic [63:0] r;
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < 8; j++) b.d[j*32 +: 32] = $urandom;
            r   = {$urandom, $urandom};
            b.u = r[59:0];
            b.k = 8'($urandom);
            b.l = (i == nb - 1);
            b.sop = (i == 0);
            b.mrd = mrd;
            if (i == 0) b.d[78:75] = mrd ? 4'b0000 : 4'($urandom_range(1, 15));
            send_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_cpl(input int nb, input logic done, input logic tail30);
        rcb_t c;
        for (int i = 0; i < nb; i++) begin
            c.w     = $urandom;
            c.w[30] = (i == 0) ? done : tail30;
            c.first = (i == 0);
            c.l     = (i == nb - 1);
            rc_q.push_back(c);
        end
    endtask

    task automatic present();
        if (send_q.size() > 0) begin
            in_rq_tvalid = 1'b1;
            in_rq_tdata  = send_q[0].d;
            in_rq_tuser  = send_q[0].u;
            in_rq_tkeep  = send_q[0].k;
            in_rq_tlast  = send_q[0].l;
        end else begin
            in_rq_tvalid = 1'b0;
            in_rq_tlast  = 1'b0;
        end
        if (rc_q.size() > 0) begin
            rc_tvalid   = 1'b1;
            rc_tdata_lo = rc_q[0].w;
            rc_tlast    = rc_q[0].l;
        end else begin
            rc_tvalid   = 1'b0;
            rc_tlast    = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_cnt = 0;
        m_last_admit = m_cycle - 100;
        m_issued = 0;
        m_stalls = 0;
    endtask

    // One clock: compare against the model at negedge, advance the model, then move the handshakes.
    task automatic tick();
        logic mrd, ok, admit, done, exp_ov, exp_ir, exp_st, iacc, racc;
        present();
        @(negedge user_clk);
        exp_st = 1'b0;
        admit  = 1'b0;
        mrd    = 1'b0;
        if (!m_busy) begin
            exp_ov = 1'b0;
            exp_ir = 1'b0;
            mrd    = in_rq_tvalid && (in_rq_tdata[78:75] == 4'b0000);
            ok     = !mrd || ((pcie_tfc_nph_av >= 2'd2) && (m_cnt < MAXO) && ((m_cycle - m_last_admit) > HOLD));
            admit  = in_rq_tvalid && ok;
            exp_st = in_rq_tvalid && !ok;
        end else begin
            exp_ov = in_rq_tvalid;
            exp_ir = out_rq_tready;
        end
        chk("out_tvalid", out_rq_tvalid, exp_ov);
        chk("in_tready", in_rq_tready, exp_ir);
        chk("np_stalled", np_stalled, exp_st);
        chk("np_outstanding", np_outstanding, m_cnt);
        if (out_rq_tvalid) begin
            if (exp_q.size() == 0) begin
                chk("out_beat_unexpected", 1'b1, 1'b0);
            end else begin
                chk("out_tdata", out_rq_tdata, exp_q[0].d);
                chk("out_ctl", {out_rq_tlast, out_rq_tkeep, out_rq_tuser}, {exp_q[0].l, exp_q[0].k, exp_q[0].u});
            end
        end
        done = rc_tvalid && rc_tready && (rc_q.size() > 0) && rc_q[0].first && rc_q[0].w[30];
        if (m_busy && in_rq_tvalid && out_rq_tready && in_rq_tlast) m_busy = 1'b0;
        if (admit) m_busy = 1'b1;
        if (admit && mrd && !done) m_cnt++;
        else if (done && !(admit && mrd) && (m_cnt > 0)) m_cnt--;
        if (admit && mrd) begin
            m_last_admit = m_cycle;
            m_issued++;
        end
        if (exp_st) m_stalls++;
        if (np_stalled) obs_stall++;
        if (out_rq_tvalid && out_rq_tready && (exp_q.size() > 0)) begin
            if (exp_q[0].sop && exp_q[0].mrd) mrd_sop_cyc.push_back(m_cycle);
            n_out_beats++;
            void'(exp_q.pop_front());
        end
        iacc = in_rq_tvalid && in_rq_tready;
        racc = rc_tvalid && rc_tready;
        m_cycle++;
        @(posedge user_clk);
        #1;
        if (iacc && (send_q.size() > 0)) void'(send_q.pop_front());
        if (racc && (rc_q.size() > 0)) void'(rc_q.pop_front());
        present();
    endtask

    initial begin
        reset_n = 1'b0;
        in_rq_tdata = 256'd0; in_rq_tuser = 60'd0; in_rq_tkeep = 8'd0;
        in_rq_tlast = 1'b0; in_rq_tvalid = 1'b0; out_rq_tready = 1'b1;
        pcie_tfc_nph_av = 2'd0; rc_tdata_lo = 32'd0; rc_tlast = 1'b0;
        rc_tvalid = 1'b0; rc_tready = 1'b1;
        m_cycle = 0; obs_stall = 0; n_out_beats = 0;
        model_reset();

        // Reset state
        #12;
        chk("reset_out_tvalid", out_rq_tvalid, 1'b0);
        chk("reset_in_tready", in_rq_tready, 1'b0);
        chk("reset_np_outstanding", np_outstanding, 8'd0);
        chk("reset_np_stalled", np_stalled, 1'b0);
        @(negedge user_clk);
        reset_n = 1'b1;
        @(posedge user_clk);
        #1;

        // Posted stream: three 3-beat MWr, one bubble each -> 9 beats in 12 cycles
        n_out_beats = 0;
        for (int i = 0; i < 3; i++) push_tlp(1'b0, 3);
        for (int i = 0; i < 12; i++) tick();
        chk("posted_beats_in_12", n_out_beats, 32'd9);

        // MRd stalled on nph_av=1 for 10 cycles, admitted once credits appear
        mrd_sop_cyc.delete();
        pcie_tfc_nph_av = 2'd1;
        obs_stall = 0;
        push_tlp(1'b1, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_cycles", obs_stall, 32'd10);
        pcie_tfc_nph_av = 2'd3;
        tick();
        chk("admit_out_tvalid", out_rq_tvalid, 1'b1);
        chk("admit_np_outstanding", np_outstanding, 8'd1);
        tick();

        // Back-to-back MRd respects the holdoff window
        push_tlp(1'b1, 1);
        for (int i = 0; i < 20 && mrd_sop_cyc.size() < 2; i++) tick();
        chk("holdoff_second_sop_seen", mrd_sop_cyc.size(), 32'd2);
        if (mrd_sop_cyc.size() == 2)
            chk("holdoff_sop_gap_ge5", (mrd_sop_cyc[1] - mrd_sop_cyc[0]) >= 5, 1'b1);

        // Limit reached: third MRd held until a completion-done frees a slot
        push_tlp(1'b1, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("limit_stalled", np_stalled, 1'b1);
        chk("limit_count", np_outstanding, 8'd2);
        push_cpl(1, 1'b1, 1'b0);
        tick();
        tick();
        chk("limit_released_tvalid", out_rq_tvalid, 1'b1);
        chk("limit_released_count", np_outstanding, 8'd2);
        tick();

        // Same-cycle admit and completion-done at count 1
        push_cpl(1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) tick();
        chk("pre_same_cycle_count", np_outstanding, 8'd1);
        push_tlp(1'b1, 1);
        push_cpl(1, 1'b1, 1'b0);
        tick();
        chk("same_cycle_count", np_outstanding, 8'd1);
        tick();

        // Bit30 only on non-first completion beats: no decrement
        push_cpl(3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("multibeat_rc_count", np_outstanding, 8'd1);

        // Backpressure mid-TLP holds valid and data
        push_tlp(1'b0, 3);
        saved_d = send_q[1].d;
        tick();
        tick();
        out_rq_tready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("bp_tvalid_held", out_rq_tvalid, 1'b1);
        chk("bp_tdata_held", out_rq_tdata, saved_d);
        out_rq_tready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            pcie_tfc_nph_av = 2'($urandom_range(0, 3));
            out_rq_tready   = ($urandom_range(0, 3) != 0);
            rc_tready       = ($urandom_range(0, 2) != 0);
            if ((send_q.size() == 0) && ($urandom_range(0, 2) == 0)) begin
                if ($urandom_range(0, 1) == 1) push_tlp(1'b1, 1);
                else push_tlp(1'b0, $urandom_range(1, 3));
            end
            if ((rc_q.size() == 0) && ($urandom_range(0, 3) == 0))
                push_cpl($urandom_range(1, 3), (m_cnt > 0) && ($urandom_range(0, 1) == 1), 1'($urandom));
            tick();
        end

`ifdef PCIE_RQ_NP_STATS_EN
        chk("stat_np_issued", stat_np_issued, m_issued);
        chk("stat_stall_cycles", stat_stall_cycles, m_stalls);
`endif

        // Async reset in the middle of a posted TLP
        out_rq_tready = 1'b1;
        pcie_tfc_nph_av = 2'd3;
        for (int i = 0; i < 20 && (send_q.size() > 0 || rc_q.size() > 0); i++) tick();
        if (m_cnt == 0) begin
            push_tlp(1'b1, 1);
            for (int i = 0; i < 15 && send_q.size() > 0; i++) tick();
        end
        push_tlp(1'b0, 3);
        tick();
        tick();
        out_rq_tready = 1'b0;
        @(posedge user_clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out_tvalid", out_rq_tvalid, 1'b0);
        chk("async_reset_in_tready", in_rq_tready, 1'b0);
        chk("async_reset_np_outstanding", np_outstanding, 8'd0);
        send_q.delete();
        exp_q.delete();
        rc_q.delete();
        present();
        @(negedge user_clk);
        reset_n = 1'b1;
        out_rq_tready = 1'b1;
        @(posedge user_clk);
        #1;
        m_cycle++;
        model_reset();
        push_tlp(1'b1, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("post_reset_count", np_outstanding, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
